// File: rtl/lv_pkg.sv
// Shared constants for the last-value register bank: capture modes and default widths.
package lv_pkg;

  typedef enum logic {
    LV_MODE_LATCH = 1'b0,
    LV_MODE_ACC   = 1'b1
  } lv_mode_e;

  localparam int LV_WIDTH     = 21;
  localparam int LV_CHANNELS  = 8;
  localparam int LV_AGE_WIDTH = 16;
  localparam int LV_SEL_W     = (LV_CHANNELS > 1) ? $clog2(LV_CHANNELS) : 1;

endpackage

// File: rtl/lv_reg_bank_if.sv
// Read-port bundle of the last-value bank: request strobe/select out, registered data/age back.
interface lv_reg_bank_if
  import lv_pkg::*;
#(
  parameter int p_width     = LV_WIDTH,
  parameter int p_age_width = LV_AGE_WIDTH,
  parameter int p_sel_w     = LV_SEL_W
);
  logic                   rd_en;
  logic [p_sel_w-1:0]     rd_sel;
  logic [p_width-1:0]     rd_data;
  logic [p_age_width-1:0] rd_age;
  logic                   rd_valid;

  modport master (output rd_en, rd_sel, input rd_data, rd_age, rd_valid);
  modport slave  (input rd_en, rd_sel, output rd_data, rd_age, rd_valid);
endinterface

// File: rtl/lv_channel.sv
// One last-value channel: spike edge detect, latch/saturating-accumulate value, age counter.
module lv_channel
  import lv_pkg::*;
#(
  parameter int p_width     = LV_WIDTH,
  parameter int p_age_width = LV_AGE_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_spike,
  input  logic [p_width-1:0]     i_addvalue,
  input  logic                   i_mode,
  input  logic                   i_clr,
  output logic [p_width-1:0]     o_value,
  output logic [p_age_width-1:0] o_age,
  output logic                   o_written
);

  logic               spike_q;
  logic               armed;
  logic               edge_det;
  logic [p_width:0]   sum;
  logic [p_width-1:0] acc_sat;

  // armed stays low after reset until the spike line is seen low, so a level
  // already high at reset release does not count as an edge.
  assign edge_det = i_spike & ~spike_q & armed;
  assign sum      = {1'b0, o_value} + {1'b0, i_addvalue};
  assign acc_sat  = sum[p_width] ? '1 : sum[p_width-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      spike_q   <= 1'b0;
      armed     <= 1'b0;
      o_value   <= '0;
      o_age     <= '0;
      o_written <= 1'b0;
    end else begin
      spike_q <= i_spike;
      armed   <= armed | ~i_spike;
      if (i_clr) begin
        o_value   <= '0;
        o_age     <= '0;
        o_written <= 1'b0;
      end else if (edge_det) begin
        o_value   <= (lv_mode_e'(i_mode) == LV_MODE_ACC) ? acc_sat : i_addvalue;
        o_age     <= '0;
        o_written <= 1'b1;
      end else if (o_age != '1) begin
        o_age <= o_age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lv_reg_bank.sv
// Bank of independent last-value channels with a shared capture value and a 1-cycle read port.
module lv_reg_bank
  import lv_pkg::*;
#(
  parameter int p_width     = LV_WIDTH,
  parameter int p_channels  = LV_CHANNELS,
  parameter int p_age_width = LV_AGE_WIDTH,
  localparam int SEL_W      = (p_channels > 1) ? $clog2(p_channels) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [p_channels-1:0]         i_spike,
  input  logic [p_width-1:0]            i_addvalue,
  input  logic                          i_mode,
  input  logic                          i_clr,
  input  logic                          i_rd_en,
  input  logic [SEL_W-1:0]              i_rd_sel,
  output logic [p_channels*p_width-1:0] o_lv,
  output logic [p_width-1:0]            o_rd_data,
  output logic [p_age_width-1:0]        o_rd_age,
  output logic                          o_rd_valid,
  output logic [p_channels-1:0]         o_written
);

  localparam int SEL_N = 1 << SEL_W;

  // Tables padded to the full select range; unused slots read as zero.
  logic [p_width-1:0]     val_tab [SEL_N];
  logic [p_age_width-1:0] age_tab [SEL_N];
  logic [1:0]             vld_pipe;

  for (genvar g = 0; g < SEL_N; g++) begin : g_ch
    if (g < p_channels) begin : g_live
      lv_channel #(
        .p_width     (p_width),
        .p_age_width (p_age_width)
      ) u_ch (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_spike    (i_spike[g]),
        .i_addvalue (i_addvalue),
        .i_mode     (i_mode),
        .i_clr      (i_clr),
        .o_value    (val_tab[g]),
        .o_age      (age_tab[g]),
        .o_written  (o_written[g])
      );
      assign o_lv[g*p_width +: p_width] = val_tab[g];
    end else begin : g_pad
      assign val_tab[g] = '0;
      assign age_tab[g] = '0;
    end
  end

  assign vld_pipe[0] = i_rd_en;
  assign o_rd_valid  = vld_pipe[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe[1] <= 1'b0;
      o_rd_data   <= '0;
      o_rd_age    <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (i_rd_en) begin
        o_rd_data <= val_tab[i_rd_sel];
        o_rd_age  <= age_tab[i_rd_sel];
      end
    end
  end

endmodule

// File: tb/tb_lv_reg_bank.sv
// Directed bench for lv_reg_bank: reads are scored through an expected-response queue.
module tb_lv_reg_bank;
  import lv_pkg::*;

  localparam int W  = 21;
  localparam int N  = 8;
  localparam int AW = 16;
  localparam int SW = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] spike;
  logic [W-1:0] addv;
  logic         mode;
  logic         clr;
  logic [N*W-1:0] lv;
  logic [N-1:0] written;

  lv_reg_bank_if #(.p_width(W), .p_age_width(AW), .p_sel_w(SW)) rd_if ();

  always #5 clk = ~clk;

  lv_reg_bank #(.p_width(W), .p_channels(N), .p_age_width(AW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_spike    (spike),
    .i_addvalue (addv),
    .i_mode     (mode),
    .i_clr      (clr),
    .i_rd_en    (rd_if.rd_en),
    .i_rd_sel   (rd_if.rd_sel),
    .o_lv       (lv),
    .o_rd_data  (rd_if.rd_data),
    .o_rd_age   (rd_if.rd_age),
    .o_rd_valid (rd_if.rd_valid),
    .o_written  (written)
  );

  typedef struct packed {
    logic [W-1:0]  d;
    logic [AW-1:0] a;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ch(input int k);
    return lv[k*W +: W];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] m, input logic [W-1:0] v, input logic md);
    spike = m; addv = v; mode = md;
    tick();
    spike = '0;
    tick();
  endtask

  task automatic rd(input int sel, input logic [W-1:0] ed, input logic [AW-1:0] ea);
    rd_exp_t e;
    e.d = ed;
    e.a = ea;
    rd_if.rd_en  = 1'b1;
    rd_if.rd_sel = sel[SW-1:0];
    exp_q.push_back(e);
    tick();
    rd_if.rd_en = 1'b0;
  endtask

  task automatic monitor;
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (rd_if.rd_valid) begin
        if (exp_q.size() == 0) chk("rd_valid_unexpected", rd_if.rd_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_if.rd_data, e.d);
          chk("rd_age", rd_if.rd_age, e.a);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    rst_n = 1'b0; spike = '0; addv = '0; mode = 1'b0; clr = 1'b0;
    rd_if.rd_en = 1'b0; rd_if.rd_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lv", |lv, 0);
    chk("rst_written", written, 0);
    chk("rst_rd_valid", rd_if.rd_valid, 0);
    rst_n = 1'b1;
    tick();

    // latch into channel 2
    spike = 8'h04; addv = 21'h00123; mode = LV_MODE_LATCH;
    tick();
    chk("latch_ch2", ch(2), 21'h00123);
    chk("latch_written", written, 8'h04);
    chk("latch_ch1_untouched", ch(1), 0);
    spike = '0;
    rd(2, 21'h00123, 0);

    // accumulate: ch0 saturates, ch4 adds normally, same cycle
    pulse(8'h01, 21'h1FFFF0, LV_MODE_LATCH);
    pulse(8'h10, 21'h00100, LV_MODE_LATCH);
    pulse(8'h11, 21'h00020, LV_MODE_ACC);
    chk("acc_sat_ch0", ch(0), 21'h1FFFFF);
    chk("acc_ch4", ch(4), 21'h00120);
    chk("acc_written", written, 8'h15);

    // held spike captures once; later addvalue change must not land
    spike = 8'h02; addv = 21'h55; mode = LV_MODE_LATCH;
    tick();
    addv = 21'h66;
    repeat (9) tick();
    spike = '0;
    tick();
    chk("held_ch1", ch(1), 21'h55);
    rd(1, 21'h55, 10);

    // read returns pre-update value while channel 5 captures
    pulse(8'h20, 21'h3, LV_MODE_LATCH);
    spike = 8'h20; addv = 21'h7;
    rd(5, 21'h3, 1);
    spike = '0;
    rd(5, 21'h7, 0);
    tick();
    chk("idle_rd_valid", rd_if.rd_valid, 0);
    chk("idle_rd_hold", rd_if.rd_data, 21'h7);

    // clear wins over a simultaneous edge
    pulse(8'h08, 21'h11, LV_MODE_LATCH);
    chk("pre_clr_ch3", ch(3), 21'h11);
    spike = 8'h08; addv = 21'h44; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ch3", ch(3), 0);
    chk("clr_written", written, 0);
    chk("clr_ch0", ch(0), 0);
    tick();
    chk("clr_no_recapture", ch(3), 0);
    spike = '0;
    rd(0, 0, 1);

    // reset mid-operation with all spikes high and a read request pending
    spike = 8'hFF; addv = 21'h9;
    tick();
    chk("all_written", written, 8'hFF);
    rd_if.rd_en = 1'b1; rd_if.rd_sel = 3'd6;
    rst_n = 1'b0;
    #1;
    chk("arst_lv", |lv, 0);
    chk("arst_written", written, 0);
    chk("arst_rd_data", rd_if.rd_data, 0);
    chk("arst_rd_age", rd_if.rd_age, 0);
    chk("arst_rd_valid", rd_if.rd_valid, 0);
    tick();
    rd_if.rd_en = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_no_capture", |lv, 0);
    chk("post_rst_written", written, 0);
    spike = '0;
    tick();
    spike = 8'h81; addv = 21'h5;
    tick();
    chk("rerise_written", written, 8'h81);
    chk("rerise_ch0", ch(0), 21'h5);
    chk("rerise_ch7", ch(7), 21'h5);
    chk("rerise_ch3", ch(3), 0);
    spike = '0;

    repeat (2) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lv_reg_bank.md
LV_REG_BANK -- requirements
Module: lv_reg_bank

Interface
REQ-001 SHALL have parameter p_width, default 21, meaning bits per stored last value.
REQ-002 SHALL have parameter p_channels, default 8, meaning number of independent last-value channels (1..64).
REQ-003 SHALL have parameter p_age_width, default 16, meaning bits of the per-channel age counter.
REQ-004 SHALL have port i_clk  input  1  meaning the single system clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port i_spike  input  p_channels  meaning per-channel spike level, synchronous to i_clk.
REQ-007 SHALL have port i_addvalue  input  p_width  meaning the value captured by every spiking channel, shared.
REQ-008 SHALL have port i_mode  input  1  meaning 0 = latch (replace), 1 = accumulate (saturating add).
REQ-009 SHALL have port i_clr  input  1  meaning synchronous clear of all channels.
REQ-010 SHALL have port i_rd_en  input  1  meaning read request strobe.
REQ-011 SHALL have port i_rd_sel  input  clog2(p_channels), min 1  meaning channel index to read.
REQ-012 SHALL have port o_lv  output  p_channels*p_width  meaning flat bus of all stored values, channel 0 in the LSBs.
REQ-013 SHALL have port o_rd_data  output  p_width  meaning registered read value.
REQ-014 SHALL have port o_rd_age  output  p_age_width  meaning registered age of the selected channel.
REQ-015 SHALL have port o_rd_valid  output  1  meaning one-cycle pulse marking o_rd_data/o_rd_age updated.
REQ-016 SHALL have port o_written  output  p_channels  meaning per-channel flag: channel captured at least once since reset/clear.

Function
REQ-017 SHALL detect a spike as a rising edge of i_spike[k] against its registered previous sample; a held level captures only once.
REQ-018 SHALL, on a detected edge in latch mode, load i_addvalue into channel k at the same clock edge the edge is detected (value visible on o_lv the next cycle).
REQ-019 SHALL, on a detected edge in accumulate mode, load min(stored + i_addvalue, 2^p_width-1) into channel k; no wrap-around.
REQ-020 SHALL, on capture, set o_written[k] to 1 and reset age[k] to 0.
REQ-021 SHALL otherwise increment age[k] by 1 each cycle, saturating at 2^p_age_width-1.
REQ-022 SHALL allow any number of channels to capture in the same cycle, each independently.
REQ-023 SHALL, when i_clr=1, zero every value, age and o_written bit; i_clr takes priority over a simultaneous spike edge; edge-detect history still updates.
REQ-024 SHALL, when i_rd_en=1, register the selected channel's pre-update value and age into o_rd_data/o_rd_age and pulse o_rd_valid one cycle later (latency 1).
REQ-025 SHALL treat i_rd_sel >= p_channels as a read returning zero data and zero age, with o_rd_valid still pulsed.
REQ-026 SHALL hold o_rd_data/o_rd_age when i_rd_en=0; o_rd_valid=0 in that cycle.
REQ-027 SHALL sample i_mode per capture; a mode change affects only subsequent captures.

Reset
REQ-028 SHALL, while i_rst_n=0, force all values, ages, o_written, o_rd_data, o_rd_age, o_rd_valid and edge-detect history to 0, independent of i_clk.
REQ-029 SHALL, on deassertion, not treat an i_spike already high as a spike edge until it falls and rises again.
REQ-030 SHALL abort any in-flight read on reset; no o_rd_valid pulse follows.

Structure
REQ-031 SHALL place mode encodings (LV_MODE_LATCH=0, LV_MODE_ACC=1) and default widths in shared package lv_pkg.
REQ-032 SHALL implement one channel (edge detect, value register, saturating adder, age counter, written flag) as sub-module lv_channel, instantiated p_channels times.
REQ-033 SHALL keep the read mux and output registers in lv_reg_bank.

Verification
REQ-034 SHALL verify: reset, i_spike[2] rises, addvalue=0x00123, mode 0 -> o_lv channel 2 = 0x00123 next cycle, o_written=0x04.
REQ-035 SHALL verify: mode 1, channel 0 at 0x1FFFF0, spike with addvalue=0x20 -> channel 0 = 0x1FFFFF (saturated).
REQ-036 SHALL verify: i_spike[1] held high 10 cycles -> exactly one capture; read of channel 1 after 10 more cycles -> o_rd_age=10 (+/- pipeline offset as defined in REQ-024).
REQ-037 SHALL verify: i_clr and i_spike[3] edge in same cycle -> channel 3 = 0, o_written[3]=0.
REQ-038 SHALL verify: i_rd_en with i_rd_sel=5 in the same cycle channel 5 captures 0x7 over old 0x3 -> o_rd_data=0x3, o_rd_valid pulses once.
REQ-039 SHALL verify: i_rst_n asserted mid-operation with i_spike=0xFF high -> all outputs 0; after release, no capture until each spike re-rises.
